axil_slave_regfile: RTL and testbench

- AXI4-Lite slave register bank that sits directly downstream of the team's AXI4-Lite interface and drives every slave-modport output.
- Holds NUM_REGS read/write registers and terminates write and read transactions with correct VALID/READY handshakes.
- Exposes the register contents and a one-cycle write strobe to local logic.
- The write and read paths are independent and may be active in the same cycle.

---
 rtl/axil_slave_regfile.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regfile.sv
// -----------------------------------------------------------------------------
// axil_slave_regfile
//
// AXI4-Lite slave register bank. Holds NUM_REGS read/write registers,
// terminates write and read transactions, and exposes the register contents
// plus a one-cycle write strobe to local logic. The write and read paths are
// independent state machines and may both be active in the same cycle.
//
// Optional feature macro: AXIL_REGFILE_SLVERR_EN
//   defined   : out-of-range accesses answer SLVERR (2'b10)
//   undefined : out-of-range accesses answer OKAY (2'b00)
//   In both builds an out-of-range write changes nothing and an out-of-range
//   read returns zero data.
//
// Parameters:
//   ADDR_WIDTH  AXI address width
//   DATA_WIDTH  AXI data width (32 or 64)
//   NUM_REGS    number of registers (power of two, >= 2)
//
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   AW*/W*/B*                 AXI4-Lite write address / data / response
//   AR*/R*                    AXI4-Lite read address / data
//   regs_flat                 register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse, wr_idx          one-cycle strobe + index of an updated register
//
// Handshake semantics: a transfer on any channel happens on the rising edge
// where both VALID and READY are high. VALID may be dropped before its
// handshake without effect; outputs VALID/data stay stable until accepted.
// -----------------------------------------------------------------------------
module axil_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic                           wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(NUM_REGS);

    // One extra bit so the limit itself is representable for any ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] RANGE_END =
        (ADDR_WIDTH + 1)'(NUM_REGS * (DATA_WIDTH / 8));

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < RANGE_END);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    // ---------------------------------------------------------------- state
    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;

    logic                    awready_q, awready_d;
    logic                    wready_q,  wready_d;
    logic                    aw_cap_q,  aw_cap_d;
    logic                    w_cap_q,   w_cap_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]        wr_idx_q,  wr_idx_d;

    logic                    arready_q, arready_d;
    logic                    rvalid_q,  rvalid_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    // ---------------------------------------------------------------- write path
    logic                    aw_hs;
    logic                    w_hs;
    logic [ADDR_WIDTH-1:0]   commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID  && wready_q;

    // Whichever half arrives last is taken straight from the bus; the earlier
    // half comes from its capture register.
    assign commit_addr = aw_cap_q ? awaddr_q : AWADDR;
    assign commit_data = w_cap_q  ? wdata_q  : WDATA;

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_cap_d   = aw_cap_q;
        w_cap_d    = w_cap_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        regs_d     = regs_q;

        case (w_state_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    awaddr_d  = AWADDR;
                    aw_cap_d  = 1'b1;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = WDATA;
                    w_cap_d  = 1'b1;
                    wready_d = 1'b0;
                end
                if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                    if (addr_in_range(commit_addr)) begin
                        regs_d[addr_idx(commit_addr)] = commit_data;
                        wr_pulse_d = 1'b1;
                        wr_idx_d   = addr_idx(commit_addr);
                        bresp_d    = RESP_OKAY;
                    end else begin
                        bresp_d    = RESP_OOR;
                    end
                    bvalid_d  = 1'b1;
                    aw_cap_d  = 1'b0;
                    w_cap_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                // BVALID is always high in this state.
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: begin
                w_state_d = W_COLLECT;
            end
        endcase
    end

    // ---------------------------------------------------------------- read path
    // Reads sample regs_q, so a read on the same edge as a write commit to the
    // same register returns the pre-write value.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && arready_q) begin
                    if (addr_in_range(ARADDR)) begin
                        rdata_d = regs_q[addr_idx(ARADDR)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_OOR;
                    end
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- flops
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q  <= W_COLLECT;
            r_state_q  <= R_IDLE;
            // READY flops reset high so the slave accepts from the first cycle.
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            arready_q  <= 1'b1;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            aw_cap_q   <= aw_cap_d;
            w_cap_q    <= w_cap_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
module tb_axil_slave_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    // ------------------------------------------------------------ clock/reset
    logic ACLK;
    logic ARESET;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [AW-1:0]    AWADDR;
    logic             AWVALID;
    logic             AWREADY;
    logic [DW-1:0]    WDATA;
    logic             WVALID;
    logic             WREADY;
    logic [1:0]       BRESP;
    logic             BVALID;
    logic             BREADY;
    logic [AW-1:0]    ARADDR;
    logic             ARVALID;
    logic             ARREADY;
    logic [DW-1:0]    RDATA;
    logic [1:0]       RRESP;
    logic             RVALID;
    logic             RREADY;
    logic [NR*DW-1:0] regs_flat;
    logic             wr_pulse;
    logic [3:0]       wr_idx;

    axil_slave_regfile #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .regs_flat(regs_flat),
        .wr_pulse (wr_pulse),
        .wr_idx   (wr_idx)
    );

    int checks = 0;
    int errors = 0;

    // Expected register contents, maintained by the bench.
    logic [DW-1:0] exp_regs [NR];

    function automatic logic [NR*DW-1:0] exp_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = exp_regs[i];
        return f;
    endfunction

    // ------------------------------------------------------------ drivers
    // All driving and sampling happens on the falling edge.
    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic drive_idle();
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0;
        ARADDR = '0; ARVALID = 1'b0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WVALID = 1'b1;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        ARADDR = a; ARVALID = 1'b1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        ARESET = 1'b1;
        drive_idle();
        BREADY = 1'b0; RREADY = 1'b0;
        repeat (2) tick();
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b expected 1", AWREADY); end
        checks++; if (WREADY !== 1'b1) begin errors++; $display("FAIL rst_wready: got %b expected 1", WREADY); end
        checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b expected 1", ARREADY); end
        checks++; if (BVALID !== 1'b0 || RVALID !== 1'b0) begin errors++; $display("FAIL rst_valids: got b=%b r=%b expected 0 0", BVALID, RVALID); end
        checks++; if (BRESP !== 2'b00 || RRESP !== 2'b00) begin errors++; $display("FAIL rst_resps: got b=%b r=%b expected 00 00", BRESP, RRESP); end
        checks++; if (RDATA !== '0 || wr_pulse !== 1'b0 || wr_idx !== 4'd0) begin errors++; $display("FAIL rst_misc: got rdata=%h pulse=%b idx=%0d expected 0", RDATA, wr_pulse, wr_idx); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL rst_regs: got %h expected %h", regs_flat, exp_flat()); end
    endtask

    task automatic test_simul_write();
        BREADY = 1'b1;
        drive_write(32'h08, 32'hDEADBEEF);
        tick();
        drive_idle();
        exp_regs[2] = 32'hDEADBEEF;
        checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL sw_b: got bvalid=%b bresp=%b expected 1 00", BVALID, BRESP); end
        checks++; if (wr_pulse !== 1'b1 || wr_idx !== 4'd2) begin errors++; $display("FAIL sw_pulse: got pulse=%b idx=%0d expected 1 2", wr_pulse, wr_idx); end
        checks++; if (regs_flat[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_reg2: got %h expected deadbeef", regs_flat[95:64]); end
        checks++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin errors++; $display("FAIL sw_ready_low: got aw=%b w=%b expected 0 0", AWREADY, WREADY); end
        tick();
        checks++; if (BVALID !== 1'b0 || wr_pulse !== 1'b0 || AWREADY !== 1'b1) begin errors++; $display("FAIL sw_after_b: got bvalid=%b pulse=%b awready=%b expected 0 0 1", BVALID, wr_pulse, AWREADY); end
        RREADY = 1'b0;
        drive_read(32'h08);
        tick();
        ARVALID = 1'b0;
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || RRESP !== 2'b00) begin errors++; $display("FAIL sw_read: got rvalid=%b rdata=%h rresp=%b expected 1 deadbeef 00", RVALID, RDATA, RRESP); end
        RREADY = 1'b1;
        tick();
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++; $display("FAIL sw_read_done: got rvalid=%b arready=%b expected 0 1", RVALID, ARREADY); end
    endtask

    task automatic test_w_before_aw();
        BREADY = 1'b1;
        WDATA = 32'h12345678; WVALID = 1'b1;
        tick();
        WVALID = 1'b0; WDATA = '0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_wait%0d: got wready=%b awready=%b bvalid=%b expected 0 1 0", i, WREADY, AWREADY, BVALID); end
            tick();
        end
        AWADDR = 32'h04; AWVALID = 1'b1;
        tick();
        drive_idle();
        exp_regs[1] = 32'h12345678;
        checks++; if (BVALID !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd1) begin errors++; $display("FAIL wfirst_commit: got bvalid=%b pulse=%b idx=%0d expected 1 1 1", BVALID, wr_pulse, wr_idx); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL wfirst_regs: got %h expected %h", regs_flat, exp_flat()); end
        tick();
    endtask

    task automatic test_bready_stall();
        BREADY = 1'b0;
        drive_write(32'h0C, 32'hA5A5A5A5);
        tick();
        exp_regs[3] = 32'hA5A5A5A5;
        drive_write(32'h10, 32'h00000001);
        for (int i = 0; i < 5; i++) begin
            checks++; if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin errors++; $display("FAIL bstall_%0d: got bvalid=%b aw=%b w=%b expected 1 0 0", i, BVALID, AWREADY, WREADY); end
            tick();
        end
        BREADY = 1'b1;
        tick();
        checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin errors++; $display("FAIL bstall_release: got bvalid=%b aw=%b w=%b expected 0 1 1", BVALID, AWREADY, WREADY); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL bstall_not_yet: got %h expected %h", regs_flat, exp_flat()); end
        tick();
        drive_idle();
        exp_regs[4] = 32'h00000001;
        checks++; if (BVALID !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd4) begin errors++; $display("FAIL bstall_second: got bvalid=%b pulse=%b idx=%0d expected 1 1 4", BVALID, wr_pulse, wr_idx); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL bstall_regs: got %h expected %h", regs_flat, exp_flat()); end
        tick();
    endtask

    task automatic test_rready_stall();
        RREADY = 1'b0;
        drive_read(32'h0C);
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (RVALID !== 1'b1 || RDATA !== 32'hA5A5A5A5 || ARREADY !== 1'b0) begin errors++; $display("FAIL rstall_%0d: got rvalid=%b rdata=%h arready=%b expected 1 a5a5a5a5 0", i, RVALID, RDATA, ARREADY); end
            tick();
        end
        RREADY = 1'b1;
        tick();
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++; $display("FAIL rstall_done: got rvalid=%b arready=%b expected 0 1", RVALID, ARREADY); end
    endtask

    task automatic test_raw_same_edge();
        BREADY = 1'b1; RREADY = 1'b0;
        drive_write(32'h10, 32'h0000FFFF);
        drive_read(32'h10);
        tick();
        drive_idle();
        exp_regs[4] = 32'h0000FFFF;
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'h1) begin errors++; $display("FAIL raw_old: got rvalid=%b rdata=%h expected 1 00000001", RVALID, RDATA); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL raw_regs: got %h expected %h", regs_flat, exp_flat()); end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        drive_read(32'h10);
        tick();
        ARVALID = 1'b0;
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'h0000FFFF) begin errors++; $display("FAIL raw_new: got rvalid=%b rdata=%h expected 1 0000ffff", RVALID, RDATA); end
        RREADY = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        BREADY = 1'b1;
        drive_write(32'h14, 32'h00000055);
        tick();
        exp_regs[5] = 32'h00000055;
        checks++; if (wr_pulse !== 1'b1 || wr_idx !== 4'd5 || AWREADY !== 1'b0) begin errors++; $display("FAIL b2b_first: got pulse=%b idx=%0d awready=%b expected 1 5 0", wr_pulse, wr_idx, AWREADY); end
        drive_write(32'h18, 32'h00000066);
        tick();
        checks++; if (BVALID !== 1'b0 || wr_pulse !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin errors++; $display("FAIL b2b_gap: got bvalid=%b pulse=%b aw=%b w=%b expected 0 0 1 1", BVALID, wr_pulse, AWREADY, WREADY); end
        tick();
        drive_idle();
        exp_regs[6] = 32'h00000066;
        checks++; if (BVALID !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd6) begin errors++; $display("FAIL b2b_second: got bvalid=%b pulse=%b idx=%0d expected 1 1 6", BVALID, wr_pulse, wr_idx); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL b2b_regs: got %h expected %h", regs_flat, exp_flat()); end
        tick();
    endtask

    task automatic test_boundary();
        // 0x3F: last register, low byte-offset bits ignored.
        BREADY = 1'b1;
        drive_write(32'h3F, 32'hCAFE000F);
        tick();
        drive_idle();
        exp_regs[15] = 32'hCAFE000F;
        checks++; if (BRESP !== 2'b00 || wr_pulse !== 1'b1 || wr_idx !== 4'd15) begin errors++; $display("FAIL bound_write: got bresp=%b pulse=%b idx=%0d expected 00 1 15", BRESP, wr_pulse, wr_idx); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL bound_regs: got %h expected %h", regs_flat, exp_flat()); end
        tick();
    endtask

    task automatic test_out_of_range();
        BREADY = 1'b1;
        drive_write(32'h40, 32'h00000077);
        tick();
        drive_idle();
        checks++; if (BVALID !== 1'b1 || BRESP !== EXP_OOR) begin errors++; $display("FAIL oor_bresp: got bvalid=%b bresp=%b expected 1 %b", BVALID, BRESP, EXP_OOR); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL oor_pulse: got %b expected 0", wr_pulse); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL oor_regs: got %h expected %h", regs_flat, exp_flat()); end
        tick();
        RREADY = 1'b0;
        drive_read(32'h40);
        tick();
        ARVALID = 1'b0;
        checks++; if (RVALID !== 1'b1 || RDATA !== '0 || RRESP !== EXP_OOR) begin errors++; $display("FAIL oor_read: got rvalid=%b rdata=%h rresp=%b expected 1 0 %b", RVALID, RDATA, RRESP, EXP_OOR); end
        RREADY = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        BREADY = 1'b0; RREADY = 1'b0;
        drive_write(32'h00, 32'h00000055);
        drive_read(32'h04);
        tick();
        drive_idle();
        checks++; if (BVALID !== 1'b1 || RVALID !== 1'b1) begin errors++; $display("FAIL rmid_pending: got bvalid=%b rvalid=%b expected 1 1", BVALID, RVALID); end
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        checks++; if (BVALID !== 1'b0 || RVALID !== 1'b0) begin errors++; $display("FAIL rmid_valids: got bvalid=%b rvalid=%b expected 0 0", BVALID, RVALID); end
        checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL rmid_regs: got %h expected 0", regs_flat); end
        checks++; if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1) begin errors++; $display("FAIL rmid_ready: got aw=%b w=%b ar=%b expected 1 1 1", AWREADY, WREADY, ARREADY); end
        tick();
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        test_reset();
        test_simul_write();
        test_w_before_aw();
        test_bready_stall();
        test_rready_stall();
        test_raw_same_edge();
        test_back_to_back();
        test_boundary();
        test_out_of_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
